// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the ID/EX issue register.
//   - funct codes decoded by the issue logic and the execute stage
//   - issue FSM state enum
//   - bubble constants loaded into the output slot when nothing issues
package ex_pkg;

   localparam logic [5:0] AND  = 6'd36;
   localparam logic [5:0] OR   = 6'd37;
   localparam logic [5:0] ADD  = 6'd32;
   localparam logic [5:0] SUB  = 6'd34;
   localparam logic [5:0] SLT  = 6'd42;
   localparam logic [5:0] SLL  = 6'd0;
   localparam logic [5:0] DIVU = 6'd27;
   localparam logic [5:0] MFHI = 6'd16;
   localparam logic [5:0] MFLO = 6'd18;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DRAIN
   } state_e;

   // A bubble is an all-zero slot; data operands are cleared with '0 at the use site
   // because their width is a per-instance parameter.
   localparam logic       BUBBLE_VALID  = 1'b0;
   localparam logic [5:0] BUBBLE_SIGNAL = 6'd0;
   localparam logic [4:0] BUBBLE_SHAMT  = 5'd0;

endpackage

// File: rtl/id_ex_issue_if.sv
// id_ex_issue_if: bundle between the ID stage, the issue register and the execute stage.
//   ID side   : valid_in, funct_in, dataA_in, dataB_in, shamt_in, flush (to issue), stall_out (back)
//   EX side   : Signal, dataA, dataB, Shamount, valid_out, div_busy (from issue)
//   master    : the driver of the ID inputs / consumer of the execute outputs
//   slave     : the issue register itself
interface id_ex_issue_if #(
   parameter int unsigned WIDTH = 32
);

   logic             valid_in;
   logic [5:0]       funct_in;
   logic [WIDTH-1:0] dataA_in;
   logic [WIDTH-1:0] dataB_in;
   logic [4:0]       shamt_in;
   logic             flush;
   logic             stall_out;

   logic [5:0]       Signal;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [4:0]       Shamount;
   logic             valid_out;
   logic             div_busy;

   modport master (
      output valid_in, funct_in, dataA_in, dataB_in, shamt_in, flush,
      input  stall_out, Signal, dataA, dataB, Shamount, valid_out, div_busy
   );

   modport slave (
      input  valid_in, funct_in, dataA_in, dataB_in, shamt_in, flush,
      output stall_out, Signal, dataA, dataB, Shamount, valid_out, div_busy
   );

endinterface

// File: rtl/issue_cnt.sv
// issue_cnt: loadable down-counter used to time the DIVU hold.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset, clears the count
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : count is zero
module issue_cnt #(
   parameter int unsigned W = 5
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX issue register feeding the execute stage ALU/shifter/divider.
//   clk     : sole clock, rising edge
//   reset   : asynchronous active-low reset; clears every register and returns to IDLE
//   io      : id_ex_issue_if.slave
//             in : valid_in, funct_in, dataA_in, dataB_in, shamt_in, flush
//             out: stall_out (combinational from state), Signal, dataA, dataB, Shamount,
//                  valid_out, div_busy
// Single-cycle ops are registered with one cycle of latency. A captured DIVU is held on
// the outputs for DIV_CYCLES cycles while the front end is stalled.
// Build option: define DIVU_DRAIN_EN to insert one bubble (DRAIN state) after every
// divide so HI/LO settles before a dependent MFHI/MFLO issues.
module id_ex_issue
   import ex_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DIV_CYCLES = 32
) (
   input logic           clk,
   input logic           reset,
   id_ex_issue_if.slave  io
);

   localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

   state_e           state_q, state_d;
   logic             valid_q, valid_d;
   logic [5:0]       signal_q, signal_d;
   logic [WIDTH-1:0] data_a_q, data_a_d;
   logic [WIDTH-1:0] data_b_q, data_b_d;
   logic [4:0]       shamt_q, shamt_d;

   logic cnt_load, cnt_dec, cnt_zero;
   logic capture, honor_flush, stall;

   issue_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_i     (cnt_load),
      .load_val_i (CNT_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      signal_d    = signal_q;
      data_a_d    = data_a_q;
      data_b_d    = data_b_q;
      shamt_d     = shamt_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      capture     = 1'b0;
      honor_flush = 1'b0;
      stall       = 1'b0;

      unique case (state_q)
         IDLE: begin
            capture     = 1'b1;
            honor_flush = 1'b1;
         end
         DIV: begin
            if (!cnt_zero) begin
               stall   = 1'b1;
               cnt_dec = 1'b1;
            end else begin
`ifdef DIVU_DRAIN_EN
               // Last hold cycle: keep IF/ID frozen one more edge and show a bubble next.
               stall    = 1'b1;
               state_d  = DRAIN;
               valid_d  = BUBBLE_VALID;
               signal_d = BUBBLE_SIGNAL;
               data_a_d = '0;
               data_b_d = '0;
               shamt_d  = BUBBLE_SHAMT;
`else
               capture = 1'b1;
`endif
            end
         end
         DRAIN: begin
            capture = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush only squashes in IDLE: once a divide is committed, the ID slot is held by
      // the stall rather than squashed, so it issues when the hold ends.
      if (capture) begin
         if (!io.valid_in || (honor_flush && io.flush)) begin
            state_d  = IDLE;
            valid_d  = BUBBLE_VALID;
            signal_d = BUBBLE_SIGNAL;
            data_a_d = '0;
            data_b_d = '0;
            shamt_d  = BUBBLE_SHAMT;
         end else begin
            valid_d  = 1'b1;
            signal_d = io.funct_in;
            data_a_d = io.dataA_in;
            data_b_d = io.dataB_in;
            shamt_d  = io.shamt_in;
            if (io.funct_in == DIVU) begin
               state_d  = DIV;
               cnt_load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         valid_q  <= 1'b0;
         signal_q <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
         shamt_q  <= '0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         signal_q <= signal_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
         shamt_q  <= shamt_d;
      end
   end

   assign io.stall_out = stall;
   assign io.div_busy  = (state_q == DIV);
   assign io.valid_out = valid_q;
   assign io.Signal    = signal_q;
   assign io.dataA     = data_a_q;
   assign io.dataB     = data_b_q;
   assign io.Shamount  = shamt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: directed plus random stimulus for id_ex_issue, checked every cycle
// against a reference model that tracks how many more cycles the current divide stays
// visible. Honours DIVU_DRAIN_EN the same way as the design.
module tb_id_ex_issue;

   localparam int unsigned WIDTH      = 32;
   localparam int unsigned DIV_CYCLES = 32;
`ifdef DIVU_DRAIN_EN
   localparam bit DRAIN_EN = 1'b1;
`else
   localparam bit DRAIN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   id_ex_issue_if #(.WIDTH(WIDTH)) ifc ();

   id_ex_issue #(
      .WIDTH      (WIDTH),
      .DIV_CYCLES (DIV_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (ifc.slave)
   );

   // Reference model state
   logic        m_valid;
   logic [5:0]  m_sig;
   logic [31:0] m_a, m_b;
   logic [4:0]  m_sh;
   int          hold_left;   // remaining cycles the held DIVU stays visible (0 = none)
   bit          in_drain;

   int n_assert = 0;
   int n_fail   = 0;
   int stall_seen, div_seen, busy_seen, mflo_seen, sub_seen;

   logic [5:0] funct_tab [10] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42,
                                  6'd0,  6'd27, 6'd16, 6'd18, 6'd63};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_bubble();
      m_valid = 1'b0;
      m_sig   = '0;
      m_a     = '0;
      m_b     = '0;
      m_sh    = '0;
   endtask

   task automatic model_reset();
      set_bubble();
      hold_left = 0;
      in_drain  = 1'b0;
   endtask

   task automatic model_edge();
      bit honor;
      if (hold_left > 1) begin
         hold_left--;
      end else if (hold_left == 1 && DRAIN_EN) begin
         set_bubble();
         hold_left = 0;
         in_drain  = 1'b1;
      end else begin
         honor     = (hold_left == 0) && !in_drain;
         hold_left = 0;
         in_drain  = 1'b0;
         if (!ifc.valid_in || (honor && ifc.flush)) begin
            set_bubble();
         end else begin
            m_valid = 1'b1;
            m_sig   = ifc.funct_in;
            m_a     = ifc.dataA_in;
            m_b     = ifc.dataB_in;
            m_sh    = ifc.shamt_in;
            if (ifc.funct_in == 6'd27) hold_left = int'(DIV_CYCLES);
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " valid_out"}, 32'(ifc.valid_out), 32'(m_valid));
      chk({tag, " Signal"},    32'(ifc.Signal),    32'(m_sig));
      chk({tag, " dataA"},     ifc.dataA,          m_a);
      chk({tag, " dataB"},     ifc.dataB,          m_b);
      chk({tag, " Shamount"},  32'(ifc.Shamount),  32'(m_sh));
      chk({tag, " stall_out"}, 32'(ifc.stall_out),
          32'((hold_left > 1) || (hold_left == 1 && DRAIN_EN)));
      chk({tag, " div_busy"},  32'(ifc.div_busy),  32'(hold_left > 0));
   endtask

   // Called at a falling edge: check the visible slot, drive the ID inputs, take one
   // rising edge through the model, and return at the next falling edge.
   task automatic cycle(input bit v, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s, input bit fl,
                        input string tag);
      check_all(tag);
      if (ifc.stall_out) stall_seen++;
      if (ifc.div_busy) busy_seen++;
      if (ifc.valid_out && ifc.Signal == 6'd27) div_seen++;
      if (ifc.valid_out && ifc.Signal == 6'd18) mflo_seen++;
      if (ifc.valid_out && ifc.Signal == 6'd34) sub_seen++;
      ifc.valid_in = v;
      ifc.funct_in = f;
      ifc.dataA_in = a;
      ifc.dataB_in = b;
      ifc.shamt_in = s;
      ifc.flush    = fl;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, tag);
   endtask

   // Pull reset low between edges, check the immediate clear, release one cycle later.
   task automatic mid_reset(input string tag);
      ifc.valid_in = 1'b0;
      ifc.flush    = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      check_all({tag, "_held"});
      reset = 1'b1;
   endtask

   task automatic clear_counts();
      stall_seen = 0;
      div_seen   = 0;
      busy_seen  = 0;
      mflo_seen  = 0;
      sub_seen   = 0;
   endtask

   initial begin
      reset        = 1'b1;
      ifc.valid_in = 1'b0;
      ifc.funct_in = '0;
      ifc.dataA_in = '0;
      ifc.dataB_in = '0;
      ifc.shamt_in = '0;
      ifc.flush    = 1'b0;
      clear_counts();
      model_reset();

      // Power-on reset
      #2 reset = 1'b0;
      #1;
      check_all("por");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Bubble captured while valid_in is low
      idle("idle0");
      idle("idle1");

      // ADD with one-cycle latency
      cycle(1'b1, 6'd32, 32'd5, 32'd7, 5'd3, 1'b0, "add_in");
      chk("add Signal", 32'(ifc.Signal), 32'd32);
      chk("add dataA", ifc.dataA, 32'd5);
      chk("add dataB", ifc.dataB, 32'd7);
      chk("add valid_out", 32'(ifc.valid_out), 32'd1);
      chk("add stall_out", 32'(ifc.stall_out), 32'd0);
      idle("add_out");

      // DIVU 100/7 followed by a stalled MFLO
      clear_counts();
      cycle(1'b1, 6'd27, 32'd100, 32'd7, 5'd0, 1'b0, "divu");
      repeat (DIV_CYCLES + DRAIN_EN) cycle(1'b1, 6'd18, 32'd0, 32'd0, 5'd0, 1'b0, "mflo_wait");
      idle("mflo_out0");
      idle("mflo_out1");
      chk("divu stall cycles", 32'(stall_seen), 32'(DIV_CYCLES - 1 + DRAIN_EN));
      chk("divu hold cycles", 32'(div_seen), 32'(DIV_CYCLES));
      chk("mflo issued once", 32'(mflo_seen), 32'd1);

      // Flush in IDLE squashes a valid SUB
      cycle(1'b1, 6'd34, 32'd9, 32'd4, 5'd0, 1'b1, "flush_idle");
      chk("flush_idle valid_out", 32'(ifc.valid_out), 32'd0);
      idle("flush_idle_out");

      // Flush during DIV is ignored; the held SUB issues after the stall
      clear_counts();
      cycle(1'b1, 6'd27, 32'd9, 32'd0, 5'd0, 1'b0, "divu_b0");
      repeat (5) cycle(1'b1, 6'd34, 32'd12, 32'd5, 5'd1, 1'b0, "sub_wait");
      repeat (10) cycle(1'b1, 6'd34, 32'd12, 32'd5, 5'd1, 1'b1, "sub_flush");
      repeat (DIV_CYCLES - 15 + DRAIN_EN) cycle(1'b1, 6'd34, 32'd12, 32'd5, 5'd1, 1'b0, "sub_wait2");
      idle("sub_out0");
      idle("sub_out1");
      chk("sub issued after flush in DIV", 32'(sub_seen), 32'd1);

      // Back-to-back DIVU
      clear_counts();
      cycle(1'b1, 6'd27, 32'd50, 32'd3, 5'd0, 1'b0, "b2b_first");
      repeat (DIV_CYCLES + DRAIN_EN) cycle(1'b1, 6'd27, 32'd60, 32'd4, 5'd0, 1'b0, "b2b_second");
      repeat (DIV_CYCLES + 2) idle("b2b_drain");
      chk("b2b busy cycles", 32'(busy_seen), 32'(2 * DIV_CYCLES));
      chk("b2b hold cycles", 32'(div_seen), 32'(2 * DIV_CYCLES));

      // Reset while the counter sits at 10
      cycle(1'b1, 6'd27, 32'd77, 32'd11, 5'd0, 1'b0, "rst_divu");
      repeat (DIV_CYCLES - 11) idle("rst_hold");
      chk("counter at 10 before reset", 32'(ifc.stall_out), 32'd1);
      mid_reset("mid_reset");
      cycle(1'b1, 6'd32, 32'd11, 32'd22, 5'd0, 1'b0, "post_rst_add");
      chk("post reset ADD Signal", 32'(ifc.Signal), 32'd32);
      chk("post reset ADD dataA", ifc.dataA, 32'd11);
      chk("post reset ADD stall", 32'(ifc.stall_out), 32'd0);
      idle("post_rst_idle");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if (i == 300) mid_reset("rand_reset");
         cycle($urandom_range(0, 3) != 0, funct_tab[$urandom_range(0, 9)], $urandom,
               $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 7) == 0, "rand");
      end
      repeat (DIV_CYCLES + 2) idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
